// File: rtl/clock_drp_arbiter.sv
// rtl/clock_drp_arbiter.sv - round-robin arbiter sharing one MMCM DRP port among N_REQ requesters
// Optional DRDY timeout: define CLOCK_DRP_ARB_TIMEOUT_EN.
module clock_drp_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_REQ-1:0]      REQ,
    input  logic [N_REQ-1:0]      REQ_WE,
    input  logic [N_REQ*7-1:0]    REQ_ADDR,
    input  logic [N_REQ*16-1:0]   REQ_DIN,
    output logic [N_REQ-1:0]      ACK,
    output logic [15:0]           RSP_DOUT,
    output logic                  RSP_ERR,
    output logic                  BUSY,
    output logic [6:0]            DADDR,
    output logic                  DEN,
    output logic                  DWE,
    output logic [15:0]           DIN,
    input  logic [15:0]           DOUT,
    input  logic                  DRDY
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("clock_drp_arbiter: N_REQ out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("clock_drp_arbiter: TIMEOUT out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_next;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   grant_q;
    logic            we_q;
    logic [IW-1:0]   pick;
    logic            found;
    logic            timeout_hit;

    logic [6:0]      addr_arr [N_REQ];
    logic [15:0]     din_arr  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g] = REQ_ADDR[7*g +: 7];
        assign din_arr[g]  = REQ_DIN[16*g +: 16];
    end

    // Scan upward from the requester after the last winner, wrapping modulo N_REQ.
    always_comb begin
        int            j;
        logic [IW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = int'(last_q) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            cand = j[IW-1:0];
            if (!found && REQ[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

`ifdef CLOCK_DRP_ARB_TIMEOUT_EN
    logic [9:0] wait_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt <= '0;
        end else if (state_q == S_ISSUE) begin
            wait_cnt <= '0;
        end else if (state_q == S_WAIT && !DRDY) begin
            wait_cnt <= wait_cnt + 10'd1;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // DRDY wins over the timeout when both land in the same WAIT cycle.
    always_comb begin
        state_next  = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE:  if (found) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (DRDY) begin
                    state_next = S_DONE;
                end
`ifdef CLOCK_DRP_ARB_TIMEOUT_EN
                else if (wait_cnt == 10'(TIMEOUT)) begin
                    state_next  = S_DONE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q   <= IW'(N_REQ - 1);
            grant_q  <= '0;
            we_q     <= 1'b0;
            ACK      <= '0;
            RSP_DOUT <= '0;
            BUSY     <= 1'b0;
            DADDR    <= '0;
            DEN      <= 1'b0;
            DWE      <= 1'b0;
            DIN      <= '0;
        end else begin
            BUSY <= (state_next != S_IDLE);
            ACK  <= '0;
            DEN  <= 1'b0;
            DWE  <= 1'b0;
            if (state_q == S_IDLE && found) begin
                grant_q <= pick;
                we_q    <= REQ_WE[pick];
                DADDR   <= addr_arr[pick];
                DIN     <= din_arr[pick];
                DEN     <= 1'b1;
                DWE     <= REQ_WE[pick];
            end
            if (state_q == S_WAIT && state_next == S_DONE) begin
                ACK      <= N_REQ'(1) << grant_q;
                RSP_DOUT <= (timeout_hit || we_q) ? 16'h0000 : DOUT;
            end
            if (state_q == S_DONE) begin
                last_q <= grant_q;
            end
        end
    end

`ifdef CLOCK_DRP_ARB_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            RSP_ERR <= 1'b0;
        end else if (state_q == S_WAIT && state_next == S_DONE) begin
            RSP_ERR <= timeout_hit;
        end
    end
`else
    assign RSP_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_clock_drp_arbiter.sv
// tb/tb_clock_drp_arbiter.sv - scoreboard bench for clock_drp_arbiter with a behavioural DRP model
module tb_clock_drp_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  REQ;
    logic [1:0]  REQ_WE;
    logic [13:0] REQ_ADDR;
    logic [31:0] REQ_DIN;
    logic [1:0]  ACK;
    logic [15:0] RSP_DOUT;
    logic        RSP_ERR;
    logic        BUSY;
    logic [6:0]  DADDR;
    logic        DEN;
    logic        DWE;
    logic [15:0] DIN;
    logic [15:0] DOUT;
    logic        DRDY;

    logic        drdy_model;
    logic        drdy_spur;
    assign DRDY = drdy_model | drdy_spur;

    clock_drp_arbiter #(.N_REQ(2), .TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
        .REQ_DIN(REQ_DIN), .ACK(ACK), .RSP_DOUT(RSP_DOUT), .RSP_ERR(RSP_ERR),
        .BUSY(BUSY), .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DIN(DIN),
        .DOUT(DOUT), .DRDY(DRDY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] din;
    } cmd_t;

    typedef struct {
        logic [1:0]  ack;
        logic [15:0] dout;
        logic        err;
        int          lat_min;
        int          lat_max;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int den_cyc = 0;
    logic outstanding = 1'b0;
    int drp_lat = 3;
    logic drp_auto = 1'b1;
    logic [15:0] drp_mem [128];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // DRP slave: answers each DEN after drp_lat cycles unless drp_auto is cleared.
    initial begin
        drdy_model = 1'b0;
        DOUT = 16'h0000;
        for (int i = 0; i < 128; i++) drp_mem[i] = 16'h0000;
        drp_mem[8'h08] = 16'h1234;
        drp_mem[8'h10] = 16'hBEEF;
        forever begin
            @(negedge CLK);
            if (DEN && drp_auto) begin
                logic [6:0]  a;
                logic        w;
                logic [15:0] d;
                a = DADDR;
                w = DWE;
                d = DIN;
                repeat (drp_lat) @(negedge CLK);
                if (w) begin
                    drp_mem[a] = d;
                    DOUT = 16'hDEAD;
                end else begin
                    DOUT = drp_mem[a];
                end
                drdy_model = 1'b1;
                @(negedge CLK);
                drdy_model = 1'b0;
                DOUT = 16'h0000;
            end
        end
    end

    // Scoreboard: commands popped on DEN, responses popped on ACK.
    always @(negedge CLK) begin
        if (DEN) begin
            check("den_without_drdy", {31'd0, outstanding}, 32'd0);
            outstanding = 1'b1;
            den_cyc = cyc;
            check("den_expected", {31'd0, cmd_q.size() != 0}, 32'd1);
            if (cmd_q.size() != 0) begin
                cmd_t c;
                c = cmd_q.pop_front();
                check("dwe", {31'd0, DWE}, {31'd0, c.we});
                check("daddr", {25'd0, DADDR}, {25'd0, c.addr});
                check("din", {16'd0, DIN}, {16'd0, c.din});
            end
        end
        if (DRDY) outstanding = 1'b0;
        if (ACK != 2'b00) begin
            outstanding = 1'b0;
            check("ack_expected", {31'd0, rsp_q.size() != 0}, 32'd1);
            if (rsp_q.size() != 0) begin
                rsp_t r;
                int   lat;
                r = rsp_q.pop_front();
                lat = cyc - den_cyc;
                check("ack", {30'd0, ACK}, {30'd0, r.ack});
                check("rsp_dout", {16'd0, RSP_DOUT}, {16'd0, r.dout});
                check("rsp_err", {31'd0, RSP_ERR}, {31'd0, r.err});
                check("ack_latency_in_range", {31'd0, (lat >= r.lat_min && lat <= r.lat_max)}, 32'd1);
            end
        end
    end

    task automatic set_fields(input int idx, input logic we, input logic [6:0] addr, input logic [15:0] din);
        REQ_WE[idx] = we;
        REQ_ADDR[7*idx +: 7] = addr;
        REQ_DIN[16*idx +: 16] = din;
    endtask

    task automatic push_cmd(input logic we, input logic [6:0] addr, input logic [15:0] din);
        cmd_t c;
        c.we = we; c.addr = addr; c.din = din;
        cmd_q.push_back(c);
    endtask

    task automatic push_rsp(input logic [1:0] ack, input logic [15:0] dout, input logic err,
                            input int lmin, input int lmax);
        rsp_t r;
        r.ack = ack; r.dout = dout; r.err = err; r.lat_min = lmin; r.lat_max = lmax;
        rsp_q.push_back(r);
    endtask

    task automatic wait_acks(input int n, input int budget);
        int got;
        int k;
        got = 0;
        k = 0;
        while (got < n && k < budget) begin
            @(negedge CLK);
            k++;
            if (ACK != 2'b00) got++;
        end
        check("ack_count_within_budget", got, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, {30'd0, ACK}, 32'd0);
        check({tag, "_rsp_dout"}, {16'd0, RSP_DOUT}, 32'd0);
        check({tag, "_rsp_err"}, {31'd0, RSP_ERR}, 32'd0);
        check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        check({tag, "_den"}, {31'd0, DEN}, 32'd0);
        check({tag, "_dwe"}, {31'd0, DWE}, 32'd0);
        check({tag, "_daddr"}, {25'd0, DADDR}, 32'd0);
        check({tag, "_din"}, {16'd0, DIN}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        REQ = '0;
        REQ_WE = '0;
        REQ_ADDR = '0;
        REQ_DIN = '0;
        drdy_spur = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        @(negedge CLK);

        // Single read from requester 0
        drp_lat = 3;
        set_fields(0, 1'b0, 7'h08, 16'h0000);
        push_cmd(1'b0, 7'h08, 16'h0000);
        push_rsp(2'b01, 16'h1234, 1'b0, 4, 4);
        REQ = 2'b01;
        @(negedge CLK);
        check("read_den_cycle1", {31'd0, DEN}, 32'd1);
        check("read_busy_cycle1", {31'd0, BUSY}, 32'd1);
        wait_acks(1, 20);
        REQ = 2'b00;
        @(negedge CLK);
        check("read_busy_after_done", {31'd0, BUSY}, 32'd0);

        // Write from requester 1
        set_fields(1, 1'b1, 7'h28, 16'hFFFF);
        push_cmd(1'b1, 7'h28, 16'hFFFF);
        push_rsp(2'b10, 16'h0000, 1'b0, 4, 4);
        REQ = 2'b10;
        wait_acks(1, 20);
        REQ = 2'b00;
        @(negedge CLK);

        // Both requesting continuously: 0,1,0,1 at minimum DRP latency
        drp_lat = 1;
        set_fields(0, 1'b0, 7'h28, 16'h0000);
        set_fields(1, 1'b0, 7'h08, 16'h0000);
        for (int t = 0; t < 2; t++) begin
            push_cmd(1'b0, 7'h28, 16'h0000);
            push_rsp(2'b01, 16'hFFFF, 1'b0, 2, 2);
            push_cmd(1'b0, 7'h08, 16'h0000);
            push_rsp(2'b10, 16'h1234, 1'b0, 2, 2);
        end
        REQ = 2'b11;
        wait_acks(4, 60);
        REQ = 2'b00;
        @(negedge CLK);

        // Reset pulse while waiting for DRDY
        drp_auto = 1'b0;
        set_fields(0, 1'b0, 7'h08, 16'h0000);
        push_cmd(1'b0, 7'h08, 16'h0000);
        REQ = 2'b01;
        repeat (4) @(negedge CLK);
        check("rst_wait_busy_before", {31'd0, BUSY}, 32'd1);
        RST = 1'b1;
        REQ = 2'b00;
        @(negedge CLK);
        RST = 1'b0;
        outstanding = 1'b0;
        check_reset_outputs("rst_wait");
        repeat (5) @(negedge CLK);
        check("rst_wait_idle_busy", {31'd0, BUSY}, 32'd0);
        drp_auto = 1'b1;
        drp_lat = 2;
        set_fields(1, 1'b0, 7'h10, 16'h0000);
        push_cmd(1'b0, 7'h10, 16'h0000);
        push_rsp(2'b10, 16'hBEEF, 1'b0, 3, 3);
        REQ = 2'b10;
        wait_acks(1, 20);
        REQ = 2'b00;
        @(negedge CLK);

        // Spurious DRDY while idle
        drdy_spur = 1'b1;
        @(negedge CLK);
        drdy_spur = 1'b0;
        check("spur_busy", {31'd0, BUSY}, 32'd0);
        check("spur_den", {31'd0, DEN}, 32'd0);
        @(negedge CLK);
        check("spur_busy_later", {31'd0, BUSY}, 32'd0);
        check("spur_rsp_hold", {16'd0, RSP_DOUT}, 32'h0000BEEF);

`ifdef CLOCK_DRP_ARB_TIMEOUT_EN
        // DRDY never arrives: timeout completion, then a late DRDY is ignored
        drp_auto = 1'b0;
        set_fields(0, 1'b0, 7'h08, 16'h0000);
        push_cmd(1'b0, 7'h08, 16'h0000);
        push_rsp(2'b01, 16'h0000, 1'b1, 17, 18);
        REQ = 2'b01;
        wait_acks(1, 40);
        REQ = 2'b00;
        repeat (5) @(negedge CLK);
        drdy_spur = 1'b1;
        @(negedge CLK);
        drdy_spur = 1'b0;
        repeat (2) @(negedge CLK);
        check("late_drdy_busy", {31'd0, BUSY}, 32'd0);
        check("late_drdy_err_hold", {31'd0, RSP_ERR}, 32'd1);
        drp_auto = 1'b1;
`endif

        repeat (3) @(negedge CLK);
        check("cmd_queue_drained", cmd_q.size(), 32'd0);
        check("rsp_queue_drained", rsp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
